// File: rtl/fp_pkg.sv
// Shared definitions for the fixed-to-minifloat encoder.
// Holds the output float format (exponent/mantissa widths, bias, largest
// finite exponent), the internal working-exponent width and the FSM states.
// No ports; imported by fx2fp_encoder and fx2fp_round.
package fp_pkg;

    localparam int EXP     = 4;
    localparam int MTS     = 3;
    localparam int BIAS    = (1 << (EXP - 1)) - 1;
    localparam int EXP_MAX = (1 << EXP) - 2;
    localparam int WIDTH_O = 1 + EXP + MTS;

    // Working exponent is wider than the field so that overflow is visible
    // before it is clipped.
    localparam int E_W     = 8;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_MAG  = 3'd1,
        S_NORM = 3'd2,
        S_RND  = 3'd3,
        S_OUT  = 3'd4
    } state_t;

endpackage

// File: rtl/fx2fp_round.sv
// Round-to-nearest-even and saturation stage of the encoder (combinational).
// Ports:
//   mts_i    truncated mantissa field
//   guard_i  first bit below the mantissa
//   sticky_i OR of all bits below the guard bit
//   exp_i    working exponent (0 for a subnormal candidate)
//   exp_o    rounded exponent field, never all-ones
//   mts_o    rounded mantissa field
//   sat_o    result clipped to the largest finite magnitude
module fx2fp_round
    import fp_pkg::*;
(
    input  logic [MTS-1:0] mts_i,
    input  logic           guard_i,
    input  logic           sticky_i,
    input  logic [E_W-1:0] exp_i,
    output logic [EXP-1:0] exp_o,
    output logic [MTS-1:0] mts_o,
    output logic           sat_o
);

    logic           up_s;
    logic [MTS:0]   sum_s;
    logic [E_W-1:0] exp_s;

    // Round half to even; a mantissa carry bumps the exponent (a subnormal
    // carry lands on exponent 1, the smallest normal), then clip.
    always_comb begin
        up_s  = guard_i & (sticky_i | mts_i[0]);
        sum_s = {1'b0, mts_i} + {{MTS{1'b0}}, up_s};
        exp_s = exp_i + {{(E_W-1){1'b0}}, sum_s[MTS]};
        if (exp_s > E_W'(EXP_MAX)) begin
            exp_o = EXP'(EXP_MAX);
            mts_o = {MTS{1'b1}};
            sat_o = 1'b1;
        end else begin
            exp_o = exp_s[EXP-1:0];
            mts_o = sum_s[MTS-1:0];
            sat_o = 1'b0;
        end
    end

endmodule

// File: rtl/fx2fp_encoder.sv
// Streaming fixed-point to minifloat encoder {sign, exp, mts}.
// One word in flight; normalisation shifts one bit per cycle.
// Optional build macro: FX2FP_SUBNORM_EN keeps subnormal results; without it
// any result whose exponent field is 0 is flushed to +0.
// Ports:
//   clk      clock, rising edge
//   rst      synchronous reset, active-high
//   in_vld   fx_in valid
//   in_rdy   encoder idle and able to accept
//   fx_in    signed fixed-point operand, FRAC fractional bits
//   out_vld  fp_out valid, held until out_rdy
//   out_rdy  downstream accepts fp_out
//   fp_out   packed minifloat result
//   sat_o    fp_out was clipped to the largest finite magnitude
module fx2fp_encoder
    import fp_pkg::*;
#(
    parameter int WIDTH_I = 20,
    parameter int FRAC    = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_vld,
    output logic               in_rdy,
    input  logic [WIDTH_I-1:0] fx_in,
    output logic               out_vld,
    input  logic               out_rdy,
    output logic [WIDTH_O-1:0] fp_out,
    output logic               sat_o
);

    localparam logic [E_W-1:0] E_INIT = E_W'(WIDTH_I - 1 - FRAC + BIAS);
    localparam int             MSB    = WIDTH_I - 1;

    state_t               state_r, state_nx_s;
    logic                 sign_r;
    logic [WIDTH_I-1:0]   mag_r;
    logic [E_W-1:0]       e_r;
    logic                 in_rdy_r, out_vld_r, sat_r;
    logic [WIDTH_O-1:0]   fp_r;

    logic                 zero_s, shift_s;
    logic [E_W-1:0]       exp_in_s;
    logic [EXP-1:0]       rnd_exp_s;
    logic [MTS-1:0]       rnd_mts_s;
    logic                 rnd_sat_s;
    logic [WIDTH_O-1:0]   enc_s;
    logic                 enc_sat_s;

    assign zero_s  = (mag_r == {WIDTH_I{1'b0}});
    // Stop at exponent 1: below that the value is subnormal and keeps its
    // leading zeros instead of shifting further.
    assign shift_s = (state_r == S_NORM) && !zero_s && !mag_r[MSB] && (e_r > E_W'(1));

    // Next-state logic.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            S_IDLE:  if (in_vld) state_nx_s = S_MAG; else state_nx_s = S_IDLE;
            S_MAG:   state_nx_s = S_NORM;
            S_NORM:  if (shift_s) state_nx_s = S_NORM; else state_nx_s = S_RND;
            S_RND:   state_nx_s = S_OUT;
            S_OUT:   if (out_rdy) state_nx_s = S_IDLE; else state_nx_s = S_OUT;
            default: state_nx_s = S_IDLE;
        endcase
    end

    // A word left unnormalised at exponent 1 is subnormal: exponent field 0,
    // mantissa taken from the same bit positions as for a normal number.
    assign exp_in_s = mag_r[MSB] ? e_r : {E_W{1'b0}};

    fx2fp_round u_round (
        .mts_i    (mag_r[MSB-1 -: MTS]),
        .guard_i  (mag_r[MSB-1-MTS]),
        .sticky_i (|mag_r[MSB-2-MTS:0]),
        .exp_i    (exp_in_s),
        .exp_o    (rnd_exp_s),
        .mts_o    (rnd_mts_s),
        .sat_o    (rnd_sat_s)
    );

    // Final packing: zero and (optionally) subnormal results.
    always_comb begin
        enc_s     = {WIDTH_O{1'b0}};
        enc_sat_s = 1'b0;
        if (zero_s) begin
            enc_s     = {WIDTH_O{1'b0}};
            enc_sat_s = 1'b0;
        end else if (rnd_exp_s == {EXP{1'b0}}) begin
`ifdef FX2FP_SUBNORM_EN
            if (rnd_mts_s == {MTS{1'b0}}) begin
                enc_s = {WIDTH_O{1'b0}};
            end else begin
                enc_s = {sign_r, rnd_exp_s, rnd_mts_s};
            end
`else
            enc_s = {WIDTH_O{1'b0}};
`endif
            enc_sat_s = 1'b0;
        end else begin
            enc_s     = {sign_r, rnd_exp_s, rnd_mts_s};
            enc_sat_s = rnd_sat_s;
        end
    end

    // State, datapath and registered handshake/result outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= S_IDLE;
            sign_r    <= 1'b0;
            mag_r     <= {WIDTH_I{1'b0}};
            e_r       <= {E_W{1'b0}};
            in_rdy_r  <= 1'b1;
            out_vld_r <= 1'b0;
            fp_r      <= {WIDTH_O{1'b0}};
            sat_r     <= 1'b0;
        end else begin
            state_r   <= state_nx_s;
            in_rdy_r  <= (state_nx_s == S_IDLE);
            out_vld_r <= (state_nx_s == S_OUT);
            case (state_r)
                S_IDLE: begin
                    if (in_vld) mag_r <= fx_in;
                end
                S_MAG: begin
                    // Magnitude in WIDTH_I unsigned bits: the most negative
                    // input maps to 2^(WIDTH_I-1) without overflow.
                    sign_r <= mag_r[MSB];
                    mag_r  <= mag_r[MSB] ? (~mag_r + WIDTH_I'(1)) : mag_r;
                    e_r    <= E_INIT;
                end
                S_NORM: begin
                    if (shift_s) begin
                        mag_r <= {mag_r[MSB-1:0], 1'b0};
                        e_r   <= e_r - E_W'(1);
                    end
                end
                S_RND: begin
                    fp_r  <= enc_s;
                    sat_r <= enc_sat_s;
                end
                default: begin
                end
            endcase
        end
    end

    assign in_rdy  = in_rdy_r;
    assign out_vld = out_vld_r;
    assign fp_out  = fp_r;
    assign sat_o   = sat_r;

endmodule

// File: tb/tb_fx2fp_encoder.sv
// Directed self-checking bench for fx2fp_encoder (WIDTH_I=20, FRAC=8, EXP=4, MTS=3).
module tb_fx2fp_encoder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_vld = 1'b0;
    logic        in_rdy;
    logic [19:0] fx_in = 20'h0;
    logic        out_vld;
    logic        out_rdy = 1'b0;
    logic [7:0]  fp_out;
    logic        sat_o;

    int n_cmp = 0;
    int n_bad = 0;

    fx2fp_encoder #(.WIDTH_I(20), .FRAC(8)) dut (
        .clk     (clk),
        .rst     (rst),
        .in_vld  (in_vld),
        .in_rdy  (in_rdy),
        .fx_in   (fx_in),
        .out_vld (out_vld),
        .out_rdy (out_rdy),
        .fp_out  (fp_out),
        .sat_o   (sat_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Present one word and return 1 ns after the accepting edge.
    task automatic send(input logic [19:0] fx, input string tag);
        int n;
        n = 0;
        while (!in_rdy && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk({tag, "_rdy_wait"}, 32'(n < 50), 32'd1);
        fx_in  = fx;
        in_vld = 1'b1;
        @(posedge clk); #1;
        in_vld = 1'b0;
        chk({tag, "_busy"}, 32'(in_rdy), 32'd0);
    endtask

    // Wait for the result, check latency/value, then take it.
    task automatic recv(input logic [7:0] exp_fp, input logic exp_sat, input int exp_lat,
                        input string tag);
        int lat;
        lat = 0;
        while (!out_vld && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        chk({tag, "_fp"},  32'(fp_out), 32'(exp_fp));
        chk({tag, "_sat"}, 32'(sat_o), 32'(exp_sat));
        out_rdy = 1'b1;
        @(posedge clk); #1;
        out_rdy = 1'b0;
        chk({tag, "_drain"}, 32'({out_vld, in_rdy}), 32'b01);
    endtask

    logic [7:0] sub1_exp;
    logic [7:0] sub3_exp;
    logic       seen_out;

    initial begin
`ifdef FX2FP_SUBNORM_EN
        sub1_exp = 8'h02;
        sub3_exp = 8'h06;
`else
        sub1_exp = 8'h00;
        sub3_exp = 8'h00;
`endif
        // Reset state
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_in_rdy",  32'(in_rdy),  32'd1);
        chk("rst_out_vld", 32'(out_vld), 32'd0);
        chk("rst_fp_out",  32'(fp_out),  32'd0);
        chk("rst_sat",     32'(sat_o),   32'd0);

        // Main function and rounding/saturation/subnormal boundaries
        send(20'h00100, "one");    recv(8'h38, 1'b0, 14, "one");
        send(20'hFFE80, "m1p5");   recv(8'hBC, 1'b0, 14, "m1p5");
        send(20'h00000, "zero");   recv(8'h00, 1'b0, 3,  "zero");
        send(20'h00110, "tie_dn"); recv(8'h38, 1'b0, 14, "tie_dn");
        send(20'h00130, "tie_up"); recv(8'h3A, 1'b0, 14, "tie_up");
        send(20'h001F0, "carry");  recv(8'h40, 1'b0, 14, "carry");
        send(20'h12C00, "sat300"); recv(8'h77, 1'b1, 6,  "sat300");
        send(20'h80000, "satneg"); recv(8'hF7, 1'b1, 3,  "satneg");
        send(20'h7FFFF, "satmax"); recv(8'h77, 1'b1, 4,  "satmax");
        send(20'h00001, "sub1");   recv(sub1_exp, 1'b0, 20, "sub1");
        send(20'h00003, "sub3");   recv(sub3_exp, 1'b0, 20, "sub3");

        // Backpressure: result held while out_rdy stays low
        send(20'h00130, "bp");
        for (int i = 0; i < 20 && !out_vld; i++) begin
            @(posedge clk); #1;
        end
        chk("bp_vld", 32'(out_vld), 32'd1);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            chk("bp_hold", 32'({out_vld, in_rdy, sat_o, fp_out}), 32'({1'b1, 1'b0, 1'b0, 8'h3A}));
        end
        recv(8'h3A, 1'b0, 0, "bp");

        // Reset while normalising: word discarded
        send(20'h00100, "rstmid");
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rstmid_in_rdy",  32'(in_rdy),  32'd1);
        chk("rstmid_out_vld", 32'(out_vld), 32'd0);
        seen_out = 1'b0;
        for (int i = 0; i < 25; i++) begin
            @(posedge clk); #1;
            if (out_vld) seen_out = 1'b1;
        end
        chk("rstmid_no_out", 32'(seen_out), 32'd0);

        // Encoder usable again after the mid-flight reset
        send(20'hFFE80, "post");   recv(8'hBC, 1'b0, 14, "post");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
